// File: rtl/fir_pkg.sv
// Shared definitions for the folded FIR: controller state encoding and default geometry.
// The fir datapath imports the same package so both sides agree on TAPS/ADDR_W.
package fir_pkg;

    localparam int TAPS_DEF   = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_IDLE  = 3'd2,
        ST_MAC   = 3'd3,
        ST_LATCH = 3'd4,
        ST_HOLD  = 3'd5
    } fir_state_e;

endpackage

// File: rtl/fir_tap_cnt.sv
// Tap index counter shared by the FLUSH and MAC sequences.
// Clear wins over enable; tc flags the last tap (TAPS-1).
module fir_tap_cnt #(
    parameter int TAPS   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

    assign tc = (cnt == ADDR_W'(TAPS - 1));

endmodule

// File: rtl/fir_fold_ctrl.sv
// Sequencer for a folded FIR: one shared MAC runs TAPS products per accepted sample.
// Drives history/coefficient RAM addresses, MAC controls and the output register; no sample arithmetic.
module fir_fold_ctrl
    import fir_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              cfg_we,
    output logic              cfg_ready,
    output logic              coef_wr_en,
    output logic [ADDR_W-1:0] coef_rd_addr,
    output logic              smp_wr_en,
    output logic              smp_wr_zero,
    output logic [ADDR_W-1:0] smp_wr_addr,
    output logic [ADDR_W-1:0] smp_rd_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              out_latch,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush_req,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    fir_state_e        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] tap_cnt;
    logic              tap_tc;
    logic              is_idle, is_flush, is_mac, is_latch;
    logic              cnt_en, cnt_clr, accept;

    assign is_idle  = (state == ST_IDLE);
    assign is_flush = (state == ST_FLUSH);
    assign is_mac   = (state == ST_MAC);
    assign is_latch = (state == ST_LATCH);

    // The counter only runs during FLUSH and MAC and wraps to 0 at the last tap,
    // so every sequence starts from tap 0 without an explicit load.
    assign cnt_en  = is_flush | is_mac;
    assign cnt_clr = ~cnt_en | tap_tc;

    fir_tap_cnt #(
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W)
    ) u_tap_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (tap_cnt),
        .tc  (tap_tc)
    );

    // Handshakes: a transfer happens in the cycle where valid and ready are both high;
    // ready never depends on a valid of the same channel, and requests outside IDLE are dropped.
    assign cfg_ready  = is_idle;
    assign in_ready   = is_idle & ~cfg_we & ~flush_req;
    assign coef_wr_en = cfg_we & cfg_ready;
    assign accept     = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_INIT;
            wr_ptr    <= '0;
            base      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_INIT:  state <= ST_FLUSH;
                ST_FLUSH: begin
                    if (tap_tc) begin
                        state  <= ST_IDLE;
                        wr_ptr <= '0;
                    end
                end
                ST_IDLE: begin
                    if (flush_req) begin
                        state <= ST_FLUSH;
                    end else if (accept) begin
                        base   <= wr_ptr;
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                        state  <= ST_MAC;
                    end
                end
                ST_MAC:   if (tap_tc) state <= ST_LATCH;
                ST_LATCH: begin
                    state     <= ST_HOLD;
                    out_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default:  state <= ST_INIT;
            endcase
        end
    end

    // Newest sample sits at base; older taps walk backwards through the circular history.
    assign smp_wr_en    = is_flush | accept;
    assign smp_wr_zero  = is_flush;
    assign smp_wr_addr  = is_flush ? tap_cnt : wr_ptr;
    assign coef_rd_addr = is_mac ? tap_cnt : '0;
    assign smp_rd_addr  = is_mac ? (base - tap_cnt) : '0;
    assign mac_en       = is_mac;
    assign mac_clr      = is_mac & (tap_cnt == '0);
    assign out_latch    = is_latch;
    assign busy         = ~is_idle & (state != ST_INIT);
    assign state_dbg    = state;

endmodule

// File: tb/tb_fir_fold_ctrl.sv
// Scoreboard bench for fir_fold_ctrl: directed scenarios push expected RAM/MAC/output events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_fir_fold_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0, cfg_we = 1'b0, out_ready = 1'b0, flush_req = 1'b0;
    logic       in_ready, cfg_ready, coef_wr_en, smp_wr_en, smp_wr_zero;
    logic       mac_clr, mac_en, out_latch, out_valid, busy;
    logic [2:0] coef_rd_addr, smp_wr_addr, smp_rd_addr, state_dbg;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [3:0] exp_wr_q[$];   // {zero, addr}
    logic [6:0] exp_mac_q[$];  // {clr, coef_addr, rd_addr}
    logic [31:0] exp_cfg_q[$]; // cycle of coefficient write
    logic [31:0] exp_lat_q[$]; // cycle out_valid rises

    logic [2:0] wr_ptr_m = '0;
    int         hs_cyc;
    logic       prev_ov = 1'b0;

    fir_fold_ctrl #(.TAPS(8), .ADDR_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cfg_we       (cfg_we),
        .cfg_ready    (cfg_ready),
        .coef_wr_en   (coef_wr_en),
        .coef_rd_addr (coef_rd_addr),
        .smp_wr_en    (smp_wr_en),
        .smp_wr_zero  (smp_wr_zero),
        .smp_wr_addr  (smp_wr_addr),
        .smp_rd_addr  (smp_rd_addr),
        .mac_clr      (mac_clr),
        .mac_en       (mac_en),
        .out_latch    (out_latch),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .flush_req    (flush_req),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [18:0] all_out();
        return {in_ready, cfg_ready, coef_wr_en, coef_rd_addr, smp_wr_en, smp_wr_zero,
                smp_wr_addr, smp_rd_addr, mac_clr, mac_en, out_latch, out_valid, busy};
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (smp_wr_en) begin
            if (exp_wr_q.size() == 0) chk("unexpected_smp_wr", {28'd0, smp_wr_zero, smp_wr_addr}, 32'hffff);
            else chk("smp_wr", {28'd0, smp_wr_zero, smp_wr_addr}, {28'd0, exp_wr_q.pop_front()});
        end
        if (mac_en) begin
            if (exp_mac_q.size() == 0) chk("unexpected_mac", {25'd0, mac_clr, coef_rd_addr, smp_rd_addr}, 32'hffff);
            else chk("mac_rd", {25'd0, mac_clr, coef_rd_addr, smp_rd_addr}, {25'd0, exp_mac_q.pop_front()});
        end
        if (coef_wr_en) begin
            if (exp_cfg_q.size() == 0) chk("unexpected_coef_wr", cyc, 32'hffff);
            else chk("coef_wr_cycle", cyc, exp_cfg_q.pop_front());
        end
        if (out_valid && !prev_ov) begin
            if (exp_lat_q.size() == 0) chk("unexpected_out_valid", cyc, 32'hffff);
            else chk("out_valid_cycle", cyc, exp_lat_q.pop_front());
        end
        prev_ov = out_valid;
    end

    // driver tasks
    task automatic push_flush();
        for (int i = 0; i < 8; i++) exp_wr_q.push_back({1'b1, 3'(i)});
    endtask

    task automatic push_sample(input int n_mac);
        exp_wr_q.push_back({1'b0, wr_ptr_m});
        for (int k = 0; k < n_mac; k++)
            exp_mac_q.push_back({(k == 0), 3'(k), 3'((int'(wr_ptr_m) + 8 - k) % 8)});
        wr_ptr_m = wr_ptr_m + 3'd1;
    endtask

    task automatic wait_hs(input logic push_lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 40);
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        hs_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push_lat) exp_lat_q.push_back(32'(hs_cyc + 10));
    endtask

    task automatic start_sample();
        push_sample(8);
        @(posedge clk); #1;
        in_valid = 1'b1;
        wait_hs(1'b1);
    endtask

    task automatic wait_result(input int hold_lo);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
        for (int i = 0; i < hold_lo; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic release_and_flush();
        push_flush();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("init_outputs", {13'd0, all_out()}, 0);
        chk("init_state", state_dbg, 0);
        repeat (8) @(negedge clk);
        chk("flush_last_in_ready", in_ready, 0);
        chk("flush_last_busy", busy, 1);
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        wr_ptr_m = '0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {13'd0, all_out()}, 0);

        // power-up flush, first sample at addr 0
        release_and_flush();
        start_sample();
        wait_result(0);

        // second sample: cfg_we during MAC ignored, consumer stalls 5 cycles
        start_sample();
        repeat (2) @(posedge clk);
        #1 cfg_we = 1'b1;
        @(negedge clk);
        chk("mac_cfg_ready", cfg_ready, 0);
        chk("mac_coef_wr_en", coef_wr_en, 0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        wait_result(5);

        // cfg_we and in_valid together: config wins, sample taken next cycle
        push_sample(8);
        @(posedge clk); #1;
        cfg_we = 1'b1;
        in_valid = 1'b1;
        exp_cfg_q.push_back(32'(cyc));
        @(negedge clk);
        chk("cfg_blocks_in_ready", in_ready, 0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        wait_hs(1'b1);
        chk("sample_after_cfg_cycle", hs_cyc, exp_lat_q[exp_lat_q.size()-1] - 10);
        wait_result(0);

        // flush from IDLE with wr_ptr=3, next sample lands at addr 0
        push_flush();
        @(posedge clk); #1;
        flush_req = 1'b1;
        @(negedge clk);
        chk("flush_blocks_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush_req = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 1);
        wr_ptr_m = '0;
        start_sample();
        wait_result(0);

        // reset during MAC k=4: outputs drop at once, then the power-up flush repeats
        push_sample(4);
        @(posedge clk); #1;
        in_valid = 1'b1;
        wait_hs(1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("midmac_reset_outputs", {13'd0, all_out()}, 0);
        @(negedge clk);
        chk("midmac_reset_state", state_dbg, 0);
        release_and_flush();
        start_sample();
        wait_result(0);

        repeat (4) @(negedge clk);
        chk("wr_q_empty", exp_wr_q.size(), 0);
        chk("mac_q_empty", exp_mac_q.size(), 0);
        chk("cfg_q_empty", exp_cfg_q.size(), 0);
        chk("lat_q_empty", exp_lat_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
